// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the three-requester bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;

    // Convert a one-hot grant into the matching mux select code.
    function automatic logic [1:0] onehot_to_sel(input logic [2:0] onehot);
        logic [1:0] sel;
        case (onehot)
            3'b010:  sel = SEL_REQ1;
            3'b100:  sel = SEL_REQ2;
            default: sel = SEL_REQ0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant/data bundle between the requesting units and the arbiter.
interface bus_arbiter_if #(
    parameter int SIZE = 16
);
    logic [2:0]      req;
    logic [SIZE-1:0] in0;
    logic [SIZE-1:0] in1;
    logic [SIZE-1:0] in2;
    logic [2:0]      gnt;
    logic [1:0]      sel;
    logic            bus_valid;
    logic [SIZE-1:0] out;

    // Requesting side drives requests and data, observes the grant and bus.
    modport master (
        output req, in0, in1, in2,
        input  gnt, sel, bus_valid, out
    );

    // Arbiter side.
    modport slave (
        input  req, in0, in1, in2,
        output gnt, sel, bus_valid, out
    );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Shared-datapath multiplexer, two- or three-way depending on IS3WAY.
module bus_arbiter_mux
    import bus_arbiter_pkg::*;
#(
    parameter int SIZE   = 16,
    parameter bit IS3WAY = 1'b1
) (
    input  logic [SIZE-1:0] in0,
    input  logic [SIZE-1:0] in1,
    input  logic [SIZE-1:0] in2,
    input  logic [1:0]      sel,
    output logic [SIZE-1:0] out
);

    // Steer the selected input onto the output; unused codes fall back to in0.
    always_comb begin
        // NOTE: out gets a value before the case so every path assigns it and no latch is inferred.
        out = in0;
        case (sel)
            SEL_REQ1: out = in1;
            SEL_REQ2: if (IS3WAY) out = in2;
            default:  ;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for one shared bus with a bounded hold time per owner.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int SIZE     = 16,
    parameter int MAX_HOLD = 8
) (
    input logic          clk,
    input logic          rst_n,
    bus_arbiter_if.slave bus
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    arb_state_t      state;
    logic [2:0]      gnt_q;
    logic [1:0]      sel_q;
    logic            valid_q;
    logic [1:0]      last_owner;
    logic [3:0]      hold_cnt;
    logic [2:0]      winner;
    logic            owner_req;
    logic [SIZE-1:0] mux_out;

    // Round-robin pick: search starts just after the last owner and wraps.
    function automatic logic [2:0] rr_pick(input logic [2:0] cand, input logic [1:0] last);
        logic [2:0] pick;
        case (last)
            2'd0:    pick = cand[1] ? 3'b010 : cand[2] ? 3'b100 : cand[0] ? 3'b001 : 3'b000;
            2'd1:    pick = cand[2] ? 3'b100 : cand[0] ? 3'b001 : cand[1] ? 3'b010 : 3'b000;
            default: pick = cand[0] ? 3'b001 : cand[1] ? 3'b010 : cand[2] ? 3'b100 : 3'b000;
        endcase
        return pick;
    endfunction

    // The current owner is masked out, so the same winner serves idle pickup,
    // release handoff and preemption alike.
    assign winner    = rr_pick(bus.req & ~gnt_q, last_owner);
    assign owner_req = |(bus.req & gnt_q);

    // Arbitration FSM with hold counter and round-robin pointer; all outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (!rst_n) begin
            state      <= IDLE;
            gnt_q      <= 3'b000;
            sel_q      <= SEL_REQ0;
            valid_q    <= 1'b0;
            last_owner <= 2'd2;
            hold_cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|winner) begin
                        state      <= GRANT;
                        gnt_q      <= winner;
                        sel_q      <= onehot_to_sel(winner);
                        valid_q    <= 1'b1;
                        last_owner <= onehot_to_sel(winner);
                        hold_cnt   <= 4'd0;
                    end
                end
                GRANT: begin
                    if ((!owner_req || hold_cnt == HOLD_LAST) && |winner) begin
                        // Release or hold limit reached with someone waiting: hand off directly.
                        gnt_q      <= winner;
                        sel_q      <= onehot_to_sel(winner);
                        last_owner <= onehot_to_sel(winner);
                        hold_cnt   <= 4'd0;
                    end else if (!owner_req) begin
                        // Released with nobody waiting; sel keeps its last value.
                        state    <= IDLE;
                        gnt_q    <= 3'b000;
                        valid_q  <= 1'b0;
                        hold_cnt <= 4'd0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    bus_arbiter_mux #(
        .SIZE   (SIZE),
        .IS3WAY (1'b1)
    ) u_mux (
        .in0 (bus.in0),
        .in1 (bus.in1),
        .in2 (bus.in2),
        .sel (sel_q),
        .out (mux_out)
    );

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.bus_valid = valid_q;
    assign bus.out       = mux_out;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a cycle model predicts each post-edge
// output set, and a negedge monitor compares the DUT against it.
module tb_bus_arbiter;

    localparam int SIZE     = 16;
    localparam int MAX_HOLD = 8;

    typedef struct {
        logic [2:0]      gnt;
        logic [1:0]      sel;
        logic            valid;
        logic [SIZE-1:0] out;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    bus_arbiter_if #(.SIZE(SIZE)) bus ();

    bus_arbiter #(
        .SIZE     (SIZE),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    // Model state: owner index (-1 = idle), last owner, and how many cycles the
    // current owner's grant has been visible.
    int         m_owner;
    int         m_last;
    int         m_held;
    logic [1:0] m_sel;
    logic       m_rst;
    logic [2:0] m_req;
    logic [SIZE-1:0] d0, d1, d2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int last, input int excl);
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (last + k) % 3;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic take(input int w);
        m_owner = w;
        m_last  = w;
        m_held  = 1;
        m_sel   = 2'(w);
    endtask

    // Apply the arbitration rules to the inputs sampled at this edge.
    task automatic model_edge();
        int w;
        if (!m_rst) begin
            m_owner = -1;
            m_last  = 2;
            m_held  = 0;
            m_sel   = 2'b00;
            return;
        end
        w = pick(m_req, m_last, m_owner);
        if (m_owner < 0 || !m_req[m_owner]) begin
            if (w >= 0) take(w);
            else begin
                m_owner = -1;
                m_held  = 0;
            end
        end else if (w >= 0 && m_held >= MAX_HOLD) begin
            take(w);
        end else begin
            m_held++;
        end
    endtask

    // Present rst_n/req for the coming edge, run the model at the edge, then
    // change the data inputs and queue the expected outputs for this cycle.
    task automatic step(input logic r, input logic [2:0] rq);
        exp_t e;
        m_rst     = r;
        m_req     = rq;
        rst_n     = r;
        bus.req   = rq;
        @(posedge clk);
        model_edge();
        #1;
        d0 = SIZE'($urandom);
        d1 = SIZE'($urandom);
        d2 = SIZE'($urandom);
        bus.in0 = d0;
        bus.in1 = d1;
        bus.in2 = d2;
        e.gnt   = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
        e.sel   = m_sel;
        e.valid = (m_owner >= 0);
        e.out   = (m_sel == 2'b00) ? d0 : (m_sel == 2'b01) ? d1 : d2;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [2:0] rq, input int n);
        for (int i = 0; i < n; i++) step(1'b1, rq);
    endtask

    task automatic do_reset();
        step(1'b0, 3'b000);
        step(1'b0, 3'b000);
    endtask

    // Monitor: compare every DUT output away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("gnt",       32'(bus.gnt),       32'(e.gnt));
            check("sel",       32'(bus.sel),       32'(e.sel));
            check("bus_valid", 32'(bus.bus_valid), 32'(e.valid));
            check("out",       32'(bus.out),       32'(e.out));
            check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            check("sel_not_11",  32'(bus.sel != 2'b11), 32'd1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        bus.req = 3'b000;
        bus.in0 = '0;
        bus.in1 = '0;
        bus.in2 = '0;
        m_owner = -1;
        m_last  = 2;
        m_held  = 0;
        m_sel   = 2'b00;

        // Single requester 0 from reset, then release to idle.
        do_reset();
        hold(3'b001, 4);
        hold(3'b000, 2);

        // All three requesting: rotation 0,1,2,0 with MAX_HOLD cycles each.
        do_reset();
        hold(3'b111, 4 * MAX_HOLD + 3);

        // Requester 1 alone for a long time, then requester 2 joins.
        do_reset();
        hold(3'b010, 20);
        hold(3'b110, 12);

        // Owner 0 releases while requester 2 waits, then everyone drops.
        do_reset();
        hold(3'b001, 3);
        hold(3'b100, 3);
        hold(3'b000, 2);

        // Reset in the middle of a grant, then priority restarts at 0.
        do_reset();
        hold(3'b010, 6);
        step(1'b0, 3'b010);
        hold(3'b011, 4);

        // Owner 0 releases exactly at the hold limit while 1 and 2 wait.
        do_reset();
        hold(3'b001, 8);
        hold(3'b110, 12);

        // Randomized run with sticky requests and rare resets.
        begin
            logic [2:0] rq;
            rq = 3'b000;
            for (int i = 0; i < 10000; i++) begin
                if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
                step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, rq);
            end
        end

        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
